// File: rtl/ifetch_pkg.sv
// Shared defaults for the instruction fetch slice: bus widths, reset address
// and output buffer depth, plus a sizing helper for occupancy counters.
package ifetch_pkg;

    localparam int IFETCH_DW       = 16;
    localparam int IFETCH_AW       = 16;
    localparam int IFETCH_RESET_PC = 0;
    localparam int IFETCH_DEPTH    = 2;

    // Bits needed to hold an occupancy count from 0 up to and including depth.
    function automatic int countWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs. Entry 0 is always the head,
// so the head outputs come straight from flops. A pop shifts the entries down
// by one, and a push writes just behind the last valid entry.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DW    = IFETCH_DW,
    parameter int AW    = IFETCH_AW,
    parameter int DEPTH = IFETCH_DEPTH,
    localparam int CW   = countWidth(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [AW-1:0] i_pushPc,
    input  logic [DW-1:0] i_pushInstr,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW-1:0] o_headPc,
    output logic [DW-1:0] o_headInstr
);

    logic [AW-1:0] r_pc    [DEPTH];
    logic [DW-1:0] r_instr [DEPTH];
    logic [CW-1:0] r_count;

    logic [AW-1:0] w_nextPc    [DEPTH];
    logic [DW-1:0] w_nextInstr [DEPTH];
    logic          w_pop;
    logic [CW-1:0] w_wrIdx;

    assign o_count     = r_count;
    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == CW'(DEPTH));
    assign o_headPc    = r_pc[0];
    assign o_headInstr = r_instr[0];

    // A pop on an empty FIFO has nothing to remove and is ignored.
    assign w_pop   = i_pop & ~o_empty;
    // Landing slot for a push, taking a simultaneous pop into account.
    assign w_wrIdx = r_count - CW'(w_pop);

    // Build the next contents: shift on pop, then drop the pushed pair into place.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_nextPc[i]    = r_pc[i];
            w_nextInstr[i] = r_instr[i];
        end
        if (w_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_nextPc[i]    = r_pc[i + 1];
                w_nextInstr[i] = r_instr[i + 1];
            end
        end
        if (i_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == w_wrIdx) begin
                    w_nextPc[i]    = i_pushPc;
                    w_nextInstr[i] = i_pushInstr;
                end
            end
        end
    end

    // Storage and occupancy; flush empties the FIFO regardless of push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
        end else begin
            if (i_flush) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(i_push) - CW'(w_pop);
            end
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= w_nextPc[i];
                r_instr[i] <= w_nextInstr[i];
            end
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit. Drives word addresses to the instruction memory,
// catches each word one cycle later and queues {pc, instr} for decode over a
// valid/ready handshake. A redirect discards everything fetched or in flight
// and restarts fetching at the new target.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int          DW       = IFETCH_DW,
    parameter int          AW       = IFETCH_AW,
    parameter int unsigned RESET_PC = IFETCH_RESET_PC,
    parameter int          DEPTH    = IFETCH_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_en,
    input  logic          redir_valid,
    input  logic [AW-1:0] redir_pc,
    output logic [AW-1:0] ibus_addr,
    input  logic [DW-1:0] ibus_dout,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst,
    output logic [AW-1:0] inst_pc
);

    localparam int CW = countWidth(DEPTH);
    localparam int OW = CW + 1;

    logic [AW-1:0] r_pcIssue;
    logic          r_infl;
    logic [AW-1:0] r_inflPc;

    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [OW-1:0] w_occupancy;

    assign ibus_addr  = r_pcIssue;
    assign inst_valid = ~w_empty;
    assign w_pop      = inst_valid & inst_ready;

    // Slots that will be taken once the in-flight word lands and this cycle's
    // pop leaves; a new fetch is only allowed if it is guaranteed a slot.
    assign w_occupancy = {1'b0, w_count} + OW'(r_infl) - OW'(w_pop);
    assign w_issue     = fetch_en & ~redir_valid & (w_occupancy < OW'(DEPTH));

    // A word returning during a redirect belongs to the abandoned stream.
    assign w_push = r_infl & ~redir_valid;

    // Fetch address and in-flight tracking; a redirect overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcIssue <= AW'(RESET_PC);
            r_infl    <= 1'b0;
            r_inflPc  <= '0;
        end else if (redir_valid) begin
            r_pcIssue <= redir_pc;
            r_infl    <= 1'b0;
        end else if (w_issue) begin
            r_pcIssue <= r_pcIssue + AW'(1);
            r_infl    <= 1'b1;
            r_inflPc  <= r_pcIssue;
        end else begin
            r_infl    <= 1'b0;
        end
    end

    ifetch_fifo #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_pushPc    (r_inflPc),
        .i_pushInstr (ibus_dout),
        .i_pop       (w_pop),
        .i_flush     (redir_valid),
        .o_count     (w_count),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_headPc    (inst_pc),
        .o_headInstr (inst)
    );

    // The issue rule reserves a slot for every fetch, so a landing word never meets a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch, paired with a behavioural instruction memory holding
// mem[a] = 16'hA000 + a. Directed scenarios check cycle timing; a randomized
// run checks the delivered stream against a sequence model.
module tb_ifetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redir_valid;
    logic [15:0] redir_pc;
    logic [15:0] ibus_addr;
    logic [15:0] ibus_dout;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc;

    int checks   = 0;
    int failures = 0;

    ifetch #(
        .DW       (16),
        .AW       (16),
        .RESET_PC (0),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .ibus_addr   (ibus_addr),
        .ibus_dout   (ibus_dout),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: one-cycle synchronous read of whatever address was presented.
    always @(posedge clk) begin
        ibus_dout <= memWord(ibus_addr);
    end

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges and releases it just after an edge; the caller is then in cycle 0.
    task automatic doReset();
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 16'h0000;
        inst_ready  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        fetch_en    = 1'b1;
        redir_valid = 1'b0;
        redir_pc    = 16'h0000;
        inst_ready  = 1'b1;
        tick();
        tick();
        checks++;
        if ({inst_valid, inst_pc, inst} !== {1'b0, 16'h0000, 16'h0000}) begin
            failures++;
            $display("[TB] FAIL reset_outputs got valid=%b pc=%h inst=%h want 0/0000/0000", inst_valid, inst_pc, inst);
        end
        checks++;
        if (ibus_addr !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_addr got %h want 0000", ibus_addr);
        end
    endtask

    task automatic test_stream();
        logic [15:0] ePc;
        doReset();
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 2) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stream_latency cyc=%0d got valid=%b want 0", c, inst_valid);
                end
            end else begin
                ePc = 16'(c - 2);
                checks++;
                if ({inst_valid, inst_pc, inst} !== {1'b1, ePc, memWord(ePc)}) begin
                    failures++;
                    $display("[TB] FAIL stream_beat cyc=%0d got %b/%h/%h want 1/%h/%h", c, inst_valid, inst_pc, inst, ePc, memWord(ePc));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ePc;
        logic [15:0] eAddr;
        doReset();
        fetch_en   = 1'b1;
        inst_ready = 1'b0;
        for (int c = 0; c < 18; c++) begin
            if (c == 10) inst_ready = 1'b1;
            if (c <= 10) begin
                eAddr = (c < 2) ? 16'(c) : 16'd2;
                checks++;
                if (ibus_addr !== eAddr) begin
                    failures++;
                    $display("[TB] FAIL bp_issue_stop cyc=%0d got addr=%h want %h", c, ibus_addr, eAddr);
                end
            end
            if (c < 2) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL bp_latency cyc=%0d got valid=%b want 0", c, inst_valid);
                end
            end else begin
                ePc = (c < 10) ? 16'h0000 : 16'(c - 10);
                checks++;
                if ({inst_valid, inst_pc, inst} !== {1'b1, ePc, memWord(ePc)}) begin
                    failures++;
                    $display("[TB] FAIL bp_beat cyc=%0d got %b/%h/%h want 1/%h/%h", c, inst_valid, inst_pc, inst, ePc, memWord(ePc));
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        logic [15:0] ePc;
        doReset();
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        redir_pc   = 16'h0040;
        for (int c = 0; c < 18; c++) begin
            redir_valid = (c == 10);
            if (c < 2 || c == 11 || c == 12) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL redir_gap cyc=%0d got valid=%b want 0", c, inst_valid);
                end
            end else begin
                ePc = (c <= 10) ? 16'(c - 2) : 16'(16'h0040 + c - 13);
                checks++;
                if ({inst_valid, inst_pc, inst} !== {1'b1, ePc, memWord(ePc)}) begin
                    failures++;
                    $display("[TB] FAIL redir_beat cyc=%0d got %b/%h/%h want 1/%h/%h", c, inst_valid, inst_pc, inst, ePc, memWord(ePc));
                end
            end
            tick();
        end
        redir_valid = 1'b0;
    endtask

    task automatic test_redirect_inflight();
        logic [15:0] target;
        logic [15:0] ePc;
        target = 16'($urandom);
        doReset();
        fetch_en   = 1'b1;
        inst_ready = 1'b0;
        redir_pc   = target;
        for (int c = 0; c < 10; c++) begin
            redir_valid = (c == 2);
            inst_ready  = (c >= 3);
            if (c == 3) begin
                checks++;
                if (ibus_addr !== target) begin
                    failures++;
                    $display("[TB] FAIL inflight_target_addr got %h want %h", ibus_addr, target);
                end
            end
            if (c < 2 || c == 3 || c == 4) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL inflight_gap cyc=%0d got valid=%b want 0", c, inst_valid);
                end
            end else begin
                ePc = (c == 2) ? 16'h0000 : 16'(target + 16'(c - 5));
                checks++;
                if ({inst_valid, inst_pc, inst} !== {1'b1, ePc, memWord(ePc)}) begin
                    failures++;
                    $display("[TB] FAIL inflight_beat cyc=%0d got %b/%h/%h want 1/%h/%h", c, inst_valid, inst_pc, inst, ePc, memWord(ePc));
                end
            end
            tick();
        end
        redir_valid = 1'b0;
    endtask

    task automatic test_wrap();
        logic [15:0] ePc;
        doReset();
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        redir_pc   = 16'hFFFE;
        for (int c = 0; c < 8; c++) begin
            redir_valid = (c == 0);
            if (c < 3) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL wrap_gap cyc=%0d got valid=%b want 0", c, inst_valid);
                end
            end else begin
                ePc = 16'(16'hFFFE + 16'(c - 3));
                checks++;
                if ({inst_valid, inst_pc, inst} !== {1'b1, ePc, memWord(ePc)}) begin
                    failures++;
                    $display("[TB] FAIL wrap_beat cyc=%0d got %b/%h/%h want 1/%h/%h", c, inst_valid, inst_pc, inst, ePc, memWord(ePc));
                end
            end
            tick();
        end
        redir_valid = 1'b0;
    endtask

    task automatic test_fetch_en_and_reset();
        logic [15:0] ePc;
        doReset();
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            fetch_en = !(c >= 6 && c <= 10);
            if (c >= 6 && c <= 11) begin
                checks++;
                if (ibus_addr !== 16'h0006) begin
                    failures++;
                    $display("[TB] FAIL fen_no_issue cyc=%0d got addr=%h want 0006", c, ibus_addr);
                end
            end
            if (c < 2 || (c >= 8 && c <= 12)) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL fen_gap cyc=%0d got valid=%b want 0", c, inst_valid);
                end
            end else begin
                ePc = (c <= 7) ? 16'(c - 2) : 16'(6 + c - 13);
                checks++;
                if ({inst_valid, inst_pc, inst} !== {1'b1, ePc, memWord(ePc)}) begin
                    failures++;
                    $display("[TB] FAIL fen_beat cyc=%0d got %b/%h/%h want 1/%h/%h", c, inst_valid, inst_pc, inst, ePc, memWord(ePc));
                end
            end
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({inst_valid, inst_pc, inst, ibus_addr} !== {1'b0, 16'h0000, 16'h0000, 16'h0000}) begin
            failures++;
            $display("[TB] FAIL async_reset got valid=%b pc=%h inst=%h addr=%h want 0/0000/0000/0000", inst_valid, inst_pc, inst, ibus_addr);
        end
        doReset();
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c < 2) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL restart_gap cyc=%0d got valid=%b want 0", c, inst_valid);
                end
            end else begin
                ePc = 16'(c - 2);
                checks++;
                if ({inst_valid, inst_pc, inst} !== {1'b1, ePc, memWord(ePc)}) begin
                    failures++;
                    $display("[TB] FAIL restart_beat cyc=%0d got %b/%h/%h want 1/%h/%h", c, inst_valid, inst_pc, inst, ePc, memWord(ePc));
                end
            end
            tick();
        end
    endtask

    // Random traffic: every accepted beat must be the next address of the
    // current stream; a redirect starts a new stream at its target.
    task automatic test_random();
        logic [15:0] expPc;
        logic        holdPrev;
        logic [15:0] holdPc;
        logic [15:0] holdInst;
        logic        redirPrev;
        int          beats;
        int          idleRun;
        int          maxIdle;
        doReset();
        expPc     = 16'h0000;
        holdPrev  = 1'b0;
        holdPc    = 16'h0000;
        holdInst  = 16'h0000;
        redirPrev = 1'b0;
        beats     = 0;
        idleRun   = 0;
        maxIdle   = 0;
        for (int c = 0; c < 3000; c++) begin
            inst_ready  = ($urandom_range(0, 9) < 7);
            fetch_en    = ($urandom_range(0, 9) < 8);
            redir_valid = ($urandom_range(0, 29) == 0);
            redir_pc    = 16'($urandom);
            if (holdPrev) begin
                checks++;
                if ({inst_valid, inst_pc, inst} !== {1'b1, holdPc, holdInst}) begin
                    failures++;
                    $display("[TB] FAIL rand_stable cyc=%0d got %b/%h/%h want 1/%h/%h", c, inst_valid, inst_pc, inst, holdPc, holdInst);
                end
            end
            if (redirPrev) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL rand_flush cyc=%0d got valid=%b want 0", c, inst_valid);
                end
            end
            if (inst_valid === 1'b1 && inst_ready) begin
                beats++;
                checks++;
                if ({inst_pc, inst} !== {expPc, memWord(expPc)}) begin
                    failures++;
                    $display("[TB] FAIL rand_beat cyc=%0d got %h/%h want %h/%h", c, inst_pc, inst, expPc, memWord(expPc));
                end
                expPc = expPc + 16'd1;
            end
            idleRun = (inst_valid === 1'b1) ? 0 : idleRun + 1;
            if (idleRun > maxIdle) maxIdle = idleRun;
            holdPrev  = inst_valid & ~inst_ready & ~redir_valid;
            holdPc    = inst_pc;
            holdInst  = inst;
            redirPrev = redir_valid;
            if (redir_valid) expPc = redir_pc;
            tick();
        end
        redir_valid = 1'b0;
        checks++;
        if (beats < 1000) begin
            failures++;
            $display("[TB] FAIL rand_progress got beats=%0d want at least 1000", beats);
        end
        checks++;
        if (maxIdle >= 40) begin
            failures++;
            $display("[TB] FAIL rand_stall got idle run=%0d want below 40", maxIdle);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 16'h0000;
        inst_ready  = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_inflight();
        test_wrap();
        test_fetch_en_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
